// File: rtl/layer_pkg.sv
// layer_pkg: op codes, FSM encoding and defaults
// shared by the layer configuration controller slice.
package layer_pkg;

  localparam int DEF_LEVEL_W = 8;

  localparam logic [1:0] OP_SET_LEVEL  = 2'd0;
  localparam logic [1:0] OP_SET_ENABLE = 2'd1;
  localparam logic [1:0] OP_FRONT      = 2'd2;
  localparam logic [1:0] OP_BACK       = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_WRITE,
    S_COMMIT
  } layer_state_t;

endpackage

// File: rtl/layer_config_ctrl_if.sv
// layer_cmd_if: valid/ready command port from game
// logic into the layer configuration controller.
interface layer_cmd_if
  import layer_pkg::*;
#(
  parameter int IDX_W   = 1,
  parameter int LEVEL_W = DEF_LEVEL_W
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [IDX_W-1:0]   cmd_idx;
  logic [LEVEL_W-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_idx,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_idx,
    input  cmd_arg,
    output cmd_ready
  );

endinterface

// File: rtl/level_scan.sv
// level_scan: walks the shadow levels one entry per
// cycle and keeps the max (front) or min (back).
module level_scan
  import layer_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int IDX_W   = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            front,
  input  logic [IDX_W-1:0]                skip,
  input  logic [WIDTH-1:0][LEVEL_W-1:0]   levels,
  output logic [LEVEL_W-1:0]              ext,
  output logic                            found,
  output logic                            done
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  logic             busy;
  logic [IDX_W-1:0] cnt;
  logic [LEVEL_W-1:0] cur;
  logic             better;

  always_comb begin
    cur = levels[0];
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == IDX_W'(i)) cur = levels[i];
    end
  end

  assign better = front ? (cur > ext) : (cur < ext);
  assign done   = busy && (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      ext   <= '0;
      found <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      found <= 1'b0;
    end else if (busy) begin
      if (cnt != skip && (!found || better)) begin
        ext   <= cur;
        found <= 1'b1;
      end
      cnt <= cnt + IDX_W'(1);
      if (cnt == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/layer_config_ctrl.sv
// layer_config_ctrl: shadow/active layer bank with
// frame-synchronous commit and front/back reordering.
module layer_config_ctrl
  import layer_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_start,
  layer_cmd_if.slave               cmd,
  output logic [WIDTH*LEVEL_W-1:0] level_out,
  output logic [WIDTH-1:0]         enable_out,
  output logic                     commit_done,
  output logic                     cmd_err,
  output logic                     cmd_sat
);

  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_SCAN   = S_SCAN;
  localparam logic [1:0] ST_WRITE  = S_WRITE;
  localparam logic [1:0] ST_COMMIT = S_COMMIT;

  logic [1:0] state;
  logic       pending;
  logic [IDX_W-1:0] tgt;
  logic       tgt_front;

  logic [WIDTH-1:0][LEVEL_W-1:0] sh_lvl;
  logic [WIDTH-1:0][LEVEL_W-1:0] act_lvl;
  logic [WIDTH-1:0]              sh_en;
  logic [WIDTH-1:0]              act_en;

  logic               accept;
  logic               idx_ok;
  logic               start;
  logic [LEVEL_W-1:0] ext;
  logic               found;
  logic               scan_done;
  logic [LEVEL_W-1:0] new_lvl;
  logic               sat;

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign idx_ok = int'(cmd.cmd_idx) < WIDTH;
  assign start  = accept && idx_ok && cmd.cmd_op[1];

  assign level_out  = act_lvl;
  assign enable_out = act_en;

  level_scan #(
    .WIDTH   (WIDTH),
    .LEVEL_W (LEVEL_W),
    .IDX_W   (IDX_W)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .front  (tgt_front),
    .skip   (tgt),
    .levels (sh_lvl),
    .ext    (ext),
    .found  (found),
    .done   (scan_done)
  );

  // Clip at the range limits instead of wrapping.
  always_comb begin
    new_lvl = ext;
    sat     = 1'b0;
    if (tgt_front) begin
      if (&ext) sat = 1'b1;
      else new_lvl = ext + LEVEL_W'(1);
    end else begin
      if (ext == '0) sat = 1'b1;
      else new_lvl = ext - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      tgt         <= '0;
      tgt_front   <= 1'b0;
      commit_done <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_sat     <= 1'b0;
      sh_en       <= '0;
      act_en      <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        sh_lvl[i]  <= LEVEL_W'(i);
        act_lvl[i] <= LEVEL_W'(i);
      end
    end else begin
      commit_done <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_sat     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (frame_start) begin
            act_lvl     <= sh_lvl;
            act_en      <= sh_en;
            commit_done <= 1'b1;
          end
          if (accept) begin
            if (!idx_ok) begin
              cmd_err <= 1'b1;
            end else if (cmd.cmd_op == OP_SET_LEVEL) begin
              for (int i = 0; i < WIDTH; i++)
                if (int'(cmd.cmd_idx) == i)
                  sh_lvl[i] <= cmd.cmd_arg;
            end else if (cmd.cmd_op == OP_SET_ENABLE) begin
              for (int i = 0; i < WIDTH; i++)
                if (int'(cmd.cmd_idx) == i)
                  sh_en[i] <= cmd.cmd_arg[0];
            end else begin
              tgt       <= cmd.cmd_idx;
              tgt_front <= (cmd.cmd_op == OP_FRONT);
              state     <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (frame_start) pending <= 1'b1;
          if (scan_done) state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (found) begin
            for (int i = 0; i < WIDTH; i++)
              if (int'(tgt) == i) sh_lvl[i] <= new_lvl;
          end
          cmd_sat <= found && sat;
          pending <= pending || frame_start;
          state   <= (pending || frame_start) ?
                     ST_COMMIT : ST_IDLE;
        end
        ST_COMMIT: begin
          act_lvl     <= sh_lvl;
          act_en      <= sh_en;
          commit_done <= 1'b1;
          pending     <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_config_ctrl.sv
// tb_layer_config_ctrl: directed vectors with a queue
// scoreboard for commit/err/sat pulses, WIDTH=4.
module tb_layer_config_ctrl;
  import layer_pkg::*;

  localparam int W  = 4;
  localparam int LW = 8;
  localparam int IW = 3;

  localparam int K_COMMIT = 0;
  localparam int K_ERR    = 1;
  localparam int K_SAT    = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic [W*LW-1:0] level_out;
  logic [W-1:0]    enable_out;
  logic commit_done, cmd_err, cmd_sat;

  layer_cmd_if #(.IDX_W(IW), .LEVEL_W(LW)) cmd_if ();

  layer_config_ctrl #(
    .WIDTH   (W),
    .LEVEL_W (LW),
    .IDX_W   (IW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .cmd         (cmd_if.slave),
    .level_out   (level_out),
    .enable_out  (enable_out),
    .commit_done (commit_done),
    .cmd_err     (cmd_err),
    .cmd_sat     (cmd_sat)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          kind;
    logic [31:0] lvl;
    logic [3:0]  en;
  } ev_t;

  ev_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push(input int k, input logic [31:0] l,
                      input logic [3:0] e);
    ev_t ev;
    ev.kind = k;
    ev.lvl  = l;
    ev.en   = e;
    exp_q.push_back(ev);
  endtask

  task automatic pop(input int k);
    ev_t ev;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_pulse: got kind %0d want none", k);
    end else begin
      ev = exp_q.pop_front();
      check("pulse_kind", 64'(k), 64'(ev.kind));
      if (k == K_COMMIT && ev.kind == K_COMMIT) begin
        check("commit_level", 64'(level_out), 64'(ev.lvl));
        check("commit_enable", 64'(enable_out), 64'(ev.en));
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (commit_done) pop(K_COMMIT);
      if (cmd_err) pop(K_ERR);
      if (cmd_sat) pop(K_SAT);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input int idx,
                      input int arg, input bit fs);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_idx   = IW'(idx);
    cmd_if.cmd_arg   = LW'(arg);
    frame_start      = fs;
    @(posedge clock);
    #1;
    cmd_if.cmd_valid = 1'b0;
    frame_start      = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(posedge clock);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic count_busy(input int req, input string nm);
    int n = 0;
    forever begin
      @(negedge clock);
      if (cmd_if.cmd_ready === 1'b1 || n > 20) break;
      n++;
    end
    check(nm, 64'(n), 64'(req));
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_level"}, 64'(level_out), 64'h03020100);
    check({nm, "_enable"}, 64'(enable_out), 64'h0);
    check({nm, "_ready"}, 64'(cmd_if.cmd_ready), 64'h1);
    check({nm, "_pulses"},
          64'({commit_done, cmd_err, cmd_sat}), 64'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = '0;
    cmd_if.cmd_idx   = '0;
    cmd_if.cmd_arg   = '0;
    cyc(2);
    reset = 1'b0;
    @(negedge clock);
    check_reset_outs("reset");
    cyc(1);

    push(K_COMMIT, 32'h03020100, 4'h0);
    frame();
    cyc(2);

    send(OP_SET_LEVEL, 2, 9, 1'b0);
    cyc(1);
    check("shadow_hidden", 64'(level_out), 64'h03020100);
    push(K_COMMIT, 32'h03090100, 4'h0);
    frame();
    cyc(2);

    send(OP_SET_LEVEL, 2, 2, 1'b0);
    send(OP_SET_ENABLE, 1, 1, 1'b0);
    send(OP_FRONT, 0, 0, 1'b0);
    count_busy(5, "front_busy");
    push(K_COMMIT, 32'h03020104, 4'h2);
    frame();
    cyc(2);
    send(OP_BACK, 3, 0, 1'b0);
    count_busy(5, "back_busy");
    push(K_COMMIT, 32'h00020104, 4'h2);
    frame();
    cyc(2);

    send(OP_SET_LEVEL, 0, 255, 1'b0);
    send(OP_SET_LEVEL, 1, 0, 1'b0);
    send(OP_SET_LEVEL, 2, 0, 1'b0);
    send(OP_SET_LEVEL, 3, 0, 1'b0);
    push(K_SAT, 32'h0, 4'h0);
    send(OP_FRONT, 1, 0, 1'b0);
    count_busy(5, "front_sat_busy");
    push(K_COMMIT, 32'h0000FFFF, 4'h2);
    frame();
    cyc(2);
    send(OP_SET_LEVEL, 0, 0, 1'b0);
    push(K_SAT, 32'h0, 4'h0);
    send(OP_BACK, 1, 0, 1'b0);
    count_busy(5, "back_sat_busy");
    push(K_COMMIT, 32'h00000000, 4'h2);
    frame();
    cyc(2);

    send(OP_SET_LEVEL, 0, 5, 1'b0);
    send(OP_SET_LEVEL, 1, 7, 1'b0);
    push(K_COMMIT, 32'h00080705, 4'h2);
    send(OP_FRONT, 2, 0, 1'b0);
    cyc(1);
    frame();
    n = 0;
    forever begin
      @(negedge clock);
      n++;
      if (commit_done === 1'b1 || n > 12) break;
    end
    check("pending_latency", 64'(n), 64'd5);
    check("ready_after_commit",
          64'(cmd_if.cmd_ready), 64'h1);
    cyc(2);

    push(K_ERR, 32'h0, 4'h0);
    send(OP_SET_ENABLE, 5, 1, 1'b0);
    cyc(2);
    push(K_COMMIT, 32'h00080705, 4'h2);
    frame();
    cyc(2);

    push(K_COMMIT, 32'h00080705, 4'h2);
    send(OP_SET_LEVEL, 3, 8'h44, 1'b1);
    cyc(1);
    push(K_COMMIT, 32'h44080705, 4'h2);
    frame();
    cyc(2);

    send(OP_FRONT, 0, 0, 1'b0);
    cyc(1);
    reset = 1'b1;
    #1;
    check_reset_outs("midscan_reset");
    cyc(1);
    reset = 1'b0;
    cyc(2);
    push(K_COMMIT, 32'h03020100, 4'h0);
    frame();
    cyc(3);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_config_ctrl.md
# layer_config_ctrl

Frame-synchronous configuration controller for the pixel joiner. It holds the per-component `level` and `enable` settings that the joiner arbitrates on, and accepts level/enable commands from game logic through a valid/ready port. It also executes "bring to front" and "send to back" commands by scanning the current levels. Edits land in a shadow bank and are copied to the active bank only at frame start, so the joiner never sees a half-updated layer order mid-frame.

## Interface
- `WIDTH`, 2, number of components (joiner inputs); ≥1
- `LEVEL_W`, 8, level width; unsigned, higher level = drawn on top
- `IDX_W`, `$clog2(WIDTH)` (min 1), command index width
- Reset: reset, asynchronous, active-high. Clock: clock.
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `frame_start`  in  1  one-cycle pulse at start of vertical blank
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  controller can accept a command
- `cmd_op`  in  2  0=SET_LEVEL, 1=SET_ENABLE, 2=FRONT, 3=BACK
- `cmd_idx`  in  IDX_W  target component
- `cmd_arg`  in  LEVEL_W  level for SET_LEVEL; bit 0 = enable for SET_ENABLE; ignored otherwise
- `level_out`  out  LEVEL_W × WIDTH  active levels, zero-extended into joiner `level`
- `enable_out`  out  WIDTH  active enables to joiner `enable`
- `commit_done`  out  1  one-cycle pulse, active bank updated this cycle
- `cmd_err`  out  1  one-cycle pulse, accepted command had `cmd_idx` ≥ WIDTH (command dropped)
- `cmd_sat`  out  1  one-cycle pulse, FRONT/BACK result clipped at range limit

## Operation
- Two banks, shadow and active. Reset value of both: level[i] = i mod 2^LEVEL_W, enable[i] = 0. Outputs after reset: `cmd_ready`=1, `commit_done`=`cmd_err`=`cmd_sat`=0.
- FSM states: IDLE, SCAN, WRITE, COMMIT.
- IDLE: `cmd_ready`=1. A handshake is `cmd_valid & cmd_ready` at a clock edge.
  - SET_LEVEL / SET_ENABLE: shadow entry written at the accept edge. Stay in IDLE.
  - FRONT / BACK: latch op and idx, go to SCAN.
  - `cmd_idx` ≥ WIDTH: command accepted, no write, `cmd_err` pulses next cycle. Stay in IDLE.
- SCAN: `cmd_ready`=0. Visit shadow entries 0..WIDTH-1, one per cycle (WIDTH cycles), skipping the target idx. Track the max (FRONT) or min (BACK). Disabled entries are included.
- WRITE: `cmd_ready`=0, one cycle.
  - FRONT: new = max+1; if max = 2^LEVEL_W−1, new = max and `cmd_sat` pulses.
  - BACK: new = min−1; if min = 0, new = 0 and `cmd_sat` pulses.
  - No other entry (WIDTH=1): level unchanged, no sat.
  - Next state: COMMIT if a commit is pending, else IDLE.
- COMMIT: `cmd_ready`=0, one cycle. Active ← shadow, `commit_done`=1, clear the pending flag, go to IDLE.
- Other entries are never renormalized; equal levels are allowed, and the joiner resolves ties.

## Timing
- `frame_start` in IDLE: active ← shadow at that edge, `commit_done` high in the following cycle. No COMMIT state is used.
- Simultaneous SET accept and `frame_start` in IDLE: the commit copies the pre-edge shadow. The SET appears in the next frame's commit.
- `frame_start` during SCAN/WRITE: the pending flag is set. COMMIT runs directly after WRITE. Latency from pulse to `commit_done` is at most WIDTH+2 cycles.
- Multiple `frame_start` pulses while pending result in a single commit.
- FRONT/BACK occupancy: `cmd_ready` low for WIDTH+1 cycles, or WIDTH+2 with a pending commit.
- SET throughput: one per cycle.
- `cmd_*` inputs must stay stable while `cmd_valid` is high and `cmd_ready` is low.
- Reset mid-operation: both banks and the FSM return to reset values immediately (asynchronous). The pending flag clears and the in-flight command is lost.

## Structure
- Package `layer_pkg`:
  - op codes `OP_SET_LEVEL`, `OP_SET_ENABLE`, `OP_FRONT`, `OP_BACK`
  - FSM state enum `layer_state_t`
  - default `LEVEL_W`
- Sub-module `level_scan`: sequential max/min accumulator. Inputs are start, op, skip index, and the shadow level array. Outputs are the extreme value, the found flag, and done. It is instantiated once.

## Test plan
- Reset, WIDTH=4: `level_out`={0,1,2,3}, `enable_out`=0, `cmd_ready`=1. A `frame_start` gives `commit_done` next cycle with outputs unchanged.
- SET_LEVEL idx 2 arg 9 → `level_out[2]` still 2 until `frame_start`. One cycle after `frame_start`, `level_out[2]`=9 and `commit_done`=1.
- FRONT idx 0 with levels {0,1,2,3} → `cmd_ready` low 5 cycles. After commit, `level_out[0]`=4. BACK idx 3 then gives 0, with no sat.
- FRONT idx 1 with levels {255,0,0,0} (LEVEL_W=8) → `level_out[1]`=255 and `cmd_sat` pulses. Follow with BACK idx 1 where the other levels are {0,0,0} → `level_out[1]`=0 and `cmd_sat` pulses.
- `frame_start` on the 2nd SCAN cycle → COMMIT follows WRITE, `commit_done` within 6 cycles, and the committed bank includes the FRONT result.
- SET_ENABLE with `cmd_idx`=5 (WIDTH=4) → `cmd_err` pulses and no bank changes. Assert `reset` mid-SCAN → all outputs return to reset values the same cycle.
